// File: rtl/vc_test_sink_arb.sv
// Round-robin val/rdy arbiter sharing one test sink among p_num_reqs requesters.
// Optional stall-timeout flag enabled by defining VC_TEST_SINK_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module vc_test_sink_arb #(
  parameter int unsigned p_msg_nbits   = 32,
  parameter int unsigned p_num_reqs    = 4,
  parameter int unsigned p_count_nbits = 16,
  parameter int unsigned p_timeout     = 1024
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [p_num_reqs-1:0]                      in_val,
  output logic [p_num_reqs-1:0]                      in_rdy,
  input  logic [p_num_reqs*p_msg_nbits-1:0]          in_msg,
  output logic                                       out_val,
  input  logic                                       out_rdy,
  output logic [$clog2(p_num_reqs)+p_msg_nbits-1:0]  out_msg,
  input  logic                                       sink_done,
  output logic [p_num_reqs*p_count_nbits-1:0]        counts,
  output logic                                       done,
  output logic                                       timeout
);

  localparam int unsigned IdW = $clog2(p_num_reqs);

  typedef enum logic {StUnlocked, StLocked} state_e;

  state_e                                   state_q, state_d;
  logic [IdW-1:0]                           lock_id_q, lock_id_d;
  logic [IdW-1:0]                           prio_q, prio_d;
  logic [p_num_reqs-1:0][p_count_nbits-1:0] counts_q, counts_d;
  logic                                     reset_reg_q;

  logic [IdW-1:0] rr_grant, rr_idx, grant;
  logic           rr_found, active, xfer;

  // State register
  always_ff @(posedge clk) begin
    reset_reg_q <= reset;
    if (reset) begin
      state_q   <= StUnlocked;
      lock_id_q <= '0;
      prio_q    <= '0;
      counts_q  <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      prio_q    <= prio_d;
      counts_q  <= counts_d;
    end
  end

  // Round-robin search starting at the priority pointer
  always_comb begin
    rr_grant = prio_q;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int unsigned k = 0; k < p_num_reqs; k++) begin
      rr_idx = prio_q + IdW'(k);
      if (!rr_found && in_val[rr_idx]) begin
        rr_found = 1'b1;
        rr_grant = rr_idx;
      end
    end
  end

  // Outputs
  always_comb begin
    grant   = (state_q == StLocked) ? lock_id_q : rr_grant;
    active  = !reset && !reset_reg_q;
    out_val = active && ((state_q == StLocked) ? in_val[lock_id_q] : (|in_val));
    xfer    = out_val && out_rdy;
    in_rdy  = '0;
    if (xfer) in_rdy[grant] = 1'b1;
    out_msg = {grant, in_msg[32'(grant)*p_msg_nbits +: p_msg_nbits]};
    done    = active && sink_done && !(|in_val) && (state_q == StUnlocked);
    counts  = counts_q;
  end

  // Next state: hold the grant once the sink has seen val without rdy
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    case (state_q)
      StUnlocked: begin
        if (out_val && !out_rdy) begin
          state_d   = StLocked;
          lock_id_d = grant;
        end
      end
      StLocked: begin
        if (xfer) state_d = StUnlocked;
      end
      default: state_d = StUnlocked;
    endcase
  end

  always_comb begin
    prio_d   = prio_q;
    counts_d = counts_q;
    if (xfer) begin
      prio_d          = grant + IdW'(1);
      counts_d[grant] = counts_q[grant] + p_count_nbits'(1);
    end
  end

`ifdef VC_TEST_SINK_ARB_TIMEOUT_EN
  localparam int unsigned StallW = $clog2(p_timeout) + 1;

  logic [StallW-1:0] stall_q, stall_d;
  logic              timeout_q, timeout_d;

  // Counter saturates at p_timeout so a long stall never wraps back below it
  always_comb begin
    stall_d = stall_q;
    if (xfer) begin
      stall_d = '0;
    end else if (out_val && !out_rdy && (stall_q != StallW'(p_timeout))) begin
      stall_d = stall_q + StallW'(1);
    end
    timeout_d = timeout_q || (stall_d == StallW'(p_timeout));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && !timeout_q && timeout_d) begin
      $display("%m: sink stall timeout, grant id %0d", grant);
    end
  end
`endif
`else
  assign timeout = 1'b0;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!$isunknown({in_val, out_rdy, sink_done}))
        else $display("%m: X on in_val/out_rdy/sink_done");
      assert (!((state_q == StLocked) && !in_val[lock_id_q]))
        else $display("%m: requester %0d dropped in_val while locked", lock_id_q);
    end
  end
`endif

endmodule

// File: tb/tb_vc_test_sink_arb.sv
// Self-checking bench for vc_test_sink_arb: directed steps, then random traffic,
// all checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_vc_test_sink_arb;
  localparam int N  = 4;
  localparam int TO = 8;
`ifdef VC_TEST_SINK_ARB_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   in_val, in_rdy;
  logic [127:0] in_msg;
  logic         out_val, out_rdy;
  logic [33:0]  out_msg;
  logic         sink_done;
  logic [63:0]  counts;
  logic         done, timeout;
  logic [31:0]  msg [4];

  assign in_msg = {msg[3], msg[2], msg[1], msg[0]};

  always #5 clk = ~clk;

  vc_test_sink_arb #(
    .p_msg_nbits  (32),
    .p_num_reqs   (4),
    .p_count_nbits(16),
    .p_timeout    (TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_msg   (in_msg),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_msg  (out_msg),
    .sink_done(sink_done),
    .counts   (counts),
    .done     (done),
    .timeout  (timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: m_held is the requester whose offer the sink has already seen (-1: none)
  int         m_prio, m_held, m_stall;
  int         m_cnt [4];
  bit         m_rr, m_to;
  logic [3:0] last_rdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic model_comb(output bit v, output int g, output logic [3:0] rdy, output bit d);
    bit active;
    bit found;
    active = !reset && !m_rr;
    g      = m_prio;
    found  = 1'b0;
    if (m_held >= 0) begin
      g = m_held;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!found && in_val[(m_prio + k) % N]) begin
          found = 1'b1;
          g     = (m_prio + k) % N;
        end
      end
    end
    v   = active && ((m_held >= 0) ? in_val[m_held] : (in_val != 4'b0));
    rdy = (v && out_rdy) ? 4'(1 << g) : 4'b0;
    d   = active && sink_done && (in_val == 4'b0) && (m_held < 0);
  endtask

  task automatic model_edge(input bit v, input int g);
    if (reset) begin
      m_prio  = 0;
      m_held  = -1;
      m_stall = 0;
      m_to    = 1'b0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else if (v && out_rdy) begin
      m_cnt[g] = (m_cnt[g] + 1) % 65536;
      m_prio   = (g + 1) % N;
      m_held   = -1;
      m_stall  = 0;
    end else if (v) begin
      if (m_held < 0) m_held = g;
      m_stall++;
      if (ToEn && m_stall >= TO) m_to = 1'b1;
    end
    m_rr = reset;
  endtask

  // One clock: check outputs at the falling edge, advance the model on the rising edge
  task automatic cycle();
    bit         v, d;
    int         g;
    logic [3:0] r;
    @(negedge clk);
    model_comb(v, g, r, d);
    chk("out_val", 64'(out_val), 64'(v));
    chk("in_rdy", 64'(in_rdy), 64'(r));
    if (v) chk("out_msg", 64'(out_msg), 64'({g[1:0], msg[g]}));
    chk("done", 64'(done), 64'(d));
    for (int i = 0; i < N; i++) begin
      chk($sformatf("count%0d", i), 64'(counts[i*16 +: 16]), 64'(m_cnt[i]));
    end
    chk("timeout", 64'(timeout), 64'(m_to));
    last_rdy = r;
    @(posedge clk);
    model_edge(v, g);
    #1;
  endtask

  // Requesters drop their offer only after their handshake
  task automatic cyc_auto();
    cycle();
    for (int i = 0; i < N; i++) if (last_rdy[i]) in_val[i] = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && in_val != 4'b0; k++) cyc_auto();
  endtask

  initial begin
    reset     = 1'b1;
    in_val    = 4'b0;
    out_rdy   = 1'b1;
    sink_done = 1'b1;
    for (int i = 0; i < N; i++) msg[i] = 32'h0;
    m_rr = 1'b1; m_prio = 0; m_held = -1; m_stall = 0; m_to = 1'b0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    last_rdy = 4'b0;
    @(posedge clk);
    model_edge(1'b0, 0);
    #1;
    cycle();
    cycle();

    // Single requester after the delayed-reset cycle
    reset  = 1'b0;
    in_val = 4'b0100;
    msg[2] = 32'hDEADBEEF;
    #2 chk("rr_gate_val", 64'(out_val), 64'd0);
    cyc_auto();
    #2 chk("single_msg", 64'(out_msg), 64'({2'd2, 32'hDEADBEEF}));
    chk("single_rdy", 64'(in_rdy), 64'(4'b0100));
    cyc_auto();
    in_val = 4'hF;
    for (int i = 0; i < N; i++) msg[i] = $urandom;
    #2 chk("single_cnt", 64'(counts[47:32]), 64'd1);
    chk("prio_after_single", 64'(out_msg[33:32]), 64'd3);

    // All requesters continuously valid
    repeat (8) begin
      for (int i = 0; i < N; i++) begin
        if (!in_val[i]) begin
          msg[i]    = $urandom;
          in_val[i] = 1'b1;
        end
      end
      cyc_auto();
    end
    #2 chk("rr_cnt0", 64'(counts[15:0]), 64'd2);
    chk("rr_cnt2", 64'(counts[47:32]), 64'd3);
    drain();

    // Backpressure: lock on 0 while 3 arrives earlier in search order
    in_val  = 4'b0001;
    msg[0]  = $urandom;
    out_rdy = 1'b0;
    cyc_auto();
    in_val[3] = 1'b1;
    msg[3]    = $urandom;
    #2 chk("lock_hold_id", 64'(out_msg[33:32]), 64'd0);
    cyc_auto();
    cyc_auto();
    out_rdy = 1'b1;
    #2 chk("lock_release_rdy", 64'(in_rdy), 64'(4'b0001));
    cyc_auto();
    out_rdy = 1'b0;
    #2 chk("after_lock_id", 64'(out_msg[33:32]), 64'd3);
    cyc_auto();

    // Reset while locked on 3
    reset = 1'b1;
    #2 chk("reset_val", 64'(out_val), 64'd0);
    cyc_auto();
    reset     = 1'b0;
    in_val[1] = 1'b1;
    msg[1]    = $urandom;
    #2 chk("rr_val", 64'(out_val), 64'd0);
    cyc_auto();
    #2 chk("reset_id", 64'(out_msg[33:32]), 64'd1);
    chk("reset_counts", counts, 64'd0);
    cyc_auto();
    out_rdy = 1'b1;
    drain();

    // Done
    sink_done = 1'b1;
    #2 chk("done_idle", 64'(done), 64'd1);
    cyc_auto();
    in_val = 4'b0010;
    msg[1] = $urandom;
    #2 chk("done_busy", 64'(done), 64'd0);
    cyc_auto();

    // Stall timeout
    in_val  = 4'b0001;
    msg[0]  = $urandom;
    out_rdy = 1'b0;
    repeat (7) cyc_auto();
    #2 chk("timeout_7", 64'(timeout), 64'd0);
    cyc_auto();
    #2 chk("timeout_8", 64'(timeout), 64'(ToEn));
    out_rdy = 1'b1;
    cyc_auto();
    #2 chk("timeout_sticky", 64'(timeout), 64'(ToEn));

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      reset     = ($urandom_range(0, 49) == 0);
      out_rdy   = ($urandom_range(0, 9) < 7);
      sink_done = $urandom_range(0, 1) == 1;
      for (int i = 0; i < N; i++) begin
        if (!in_val[i] && $urandom_range(0, 2) == 0) begin
          msg[i]    = $urandom;
          in_val[i] = 1'b1;
        end
      end
      cyc_auto();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
